// File: rtl/ex_result_fifo.sv
// First-word-fall-through result FIFO between EX and the next stage.
// Registered storage, flush with drop accounting, sticky overflow flag.
module ex_result_fifo #(
   parameter int DATA_W = 32,
   parameter int CTRL_W = 16,
   parameter int DEPTH  = 4,
   parameter int CNT_W  = 16
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic [CTRL_W-1:0]        in_ctrl,
   input  logic [DATA_W-1:0]        in_alu_data,
   input  logic [DATA_W-1:0]        in_memory_data,
   input  logic [DATA_W-1:0]        in_pc,
   input  logic                     in_overflow_flag,
   input  logic                     in_zero_flag,
   input  logic                     in_compflg,
   input  logic                     flush,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [CTRL_W-1:0]        out_ctrl,
   output logic [DATA_W-1:0]        out_alu_data,
   output logic [DATA_W-1:0]        out_memory_data,
   output logic [DATA_W-1:0]        out_pc,
   output logic                     out_overflow_flag,
   output logic                     out_zero_flag,
   output logic                     out_compflg,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     overflow_err,
   output logic [CNT_W-1:0]         drop_cnt
);
   localparam int PTR_W = $clog2(DEPTH);
   localparam int ENT_W = CTRL_W + 3*DATA_W + 3;

   logic [ENT_W-1:0] mem_q [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [PTR_W:0]   count_q, count_d;
   logic             ovf_q, ovf_d;
   logic [CNT_W-1:0] drop_q, drop_d;
   logic             push, pop;
   logic [ENT_W-1:0] in_ent, head;

   function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a,
                                                 input logic [PTR_W:0]   b);
      logic [CNT_W:0] s;
      s = {1'b0, a} + (CNT_W+1)'(b);
      return s[CNT_W] ? {CNT_W{1'b1}} : s[CNT_W-1:0];
   endfunction

   assign in_ready  = (count_q != (PTR_W+1)'(DEPTH));
   assign out_valid = (count_q != '0);
   assign push      = in_valid & in_ready;
   assign pop       = out_valid & out_ready;
   assign in_ent    = {in_ctrl, in_alu_data, in_memory_data, in_pc,
                       in_overflow_flag, in_zero_flag, in_compflg};

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      drop_d   = drop_q;
      ovf_d    = ovf_q | (in_valid & ~in_ready & ~flush);
      // Flush wins over any handshake on the same edge.
      if (flush) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
         drop_d   = sat_add(drop_q, count_q);
      end else begin
         if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
         if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
         case ({push, pop})
            2'b10:   count_d = count_q + (PTR_W+1)'(1);
            2'b01:   count_d = count_q - (PTR_W+1)'(1);
            default: count_d = count_q;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         ovf_q    <= 1'b0;
         drop_q   <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         ovf_q    <= ovf_d;
         drop_q   <= drop_d;
      end
   end

   // Storage is never reset; the pointers alone define which entries are live.
   always_ff @(posedge clk) begin
      if (push && !flush) mem_q[wr_ptr_q] <= in_ent;
   end

   assign head = out_valid ? mem_q[rd_ptr_q] : '0;
   assign {out_ctrl, out_alu_data, out_memory_data, out_pc,
           out_overflow_flag, out_zero_flag, out_compflg} = head;

   assign count        = count_q;
   assign overflow_err = ovf_q;
   assign drop_cnt     = drop_q;
endmodule

// File: tb/tb_ex_result_fifo.sv
// Scoreboard bench for ex_result_fifo: stimulus queues expected entries,
// a negedge monitor pops and compares on every DUT handshake.
module tb_ex_result_fifo;
   localparam int DW = 32;
   localparam int CW = 16;
   localparam int DP = 4;
   localparam int NW = 4;

   typedef struct packed {
      logic [CW-1:0] ctrl;
      logic [DW-1:0] alu;
      logic [DW-1:0] mem;
      logic [DW-1:0] pc;
      logic [2:0]    flg;
   } ent_t;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          in_valid = 1'b0;
   logic          in_ready;
   logic [CW-1:0] in_ctrl = '0;
   logic [DW-1:0] in_alu_data = '0, in_memory_data = '0, in_pc = '0;
   logic          in_overflow_flag = 1'b0, in_zero_flag = 1'b0, in_compflg = 1'b0;
   logic          flush = 1'b0;
   logic          out_valid;
   logic          out_ready = 1'b0;
   logic [CW-1:0] out_ctrl;
   logic [DW-1:0] out_alu_data, out_memory_data, out_pc;
   logic          out_overflow_flag, out_zero_flag, out_compflg;
   logic [2:0]    count;
   logic          overflow_err;
   logic [NW-1:0] drop_cnt;

   int   n_cmp = 0;
   int   n_err = 0;
   ent_t q[$];
   ent_t exp_e;

   ex_result_fifo #(.DATA_W(DW), .CTRL_W(CW), .DEPTH(DP), .CNT_W(NW)) dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(in_ready), .in_ctrl(in_ctrl),
      .in_alu_data(in_alu_data), .in_memory_data(in_memory_data), .in_pc(in_pc),
      .in_overflow_flag(in_overflow_flag), .in_zero_flag(in_zero_flag),
      .in_compflg(in_compflg), .flush(flush),
      .out_valid(out_valid), .out_ready(out_ready), .out_ctrl(out_ctrl),
      .out_alu_data(out_alu_data), .out_memory_data(out_memory_data), .out_pc(out_pc),
      .out_overflow_flag(out_overflow_flag), .out_zero_flag(out_zero_flag),
      .out_compflg(out_compflg), .count(count), .overflow_err(overflow_err),
      .drop_cnt(drop_cnt)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   function automatic ent_t mk(input int k, input logic [DW-1:0] pc);
      ent_t e;
      e.ctrl = 16'hA000 ^ k[15:0];
      e.alu  = 32'h1111_0000 + k;
      e.mem  = 32'h2222_0000 ^ k;
      e.pc   = pc;
      e.flg  = k[2:0];
      return e;
   endfunction

   task automatic drive(input ent_t e);
      in_valid = 1'b1;
      {in_ctrl, in_alu_data, in_memory_data, in_pc,
       in_overflow_flag, in_zero_flag, in_compflg} = e;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Monitor: a handshake seen at negedge completes on the next rising edge.
   always @(negedge clk) begin
      if (!rst && !flush && out_valid && out_ready) begin
         if (q.size() == 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL pop_unexpected: got pc %0h expected no entry", out_pc);
         end else begin
            exp_e = q.pop_front();
            chk("pop_pc",   out_pc, exp_e.pc);
            chk("pop_ctrl", out_ctrl, exp_e.ctrl);
            chk("pop_alu",  out_alu_data, exp_e.alu);
            chk("pop_mem",  out_memory_data, exp_e.mem);
            chk("pop_flg",  {out_overflow_flag, out_zero_flag, out_compflg}, exp_e.flg);
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      ent_t e;
      // Reset state
      tick(); tick();
      rst = 1'b0;
      chk("rst_count", count, 0);
      chk("rst_in_ready", in_ready, 1);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_ovf", overflow_err, 0);
      chk("rst_drop", drop_cnt, 0);
      chk("rst_out_pc", out_pc, 0);
      chk("rst_out_alu", out_alu_data, 0);

      // Latency: visible only after the push edge
      e = mk(1, 32'h50);
      e.alu = 32'hDEADBEEF;
      drive(e);
      q.push_back(e);
      chk("lat_before_valid", out_valid, 0);
      chk("lat_before_alu", out_alu_data, 0);
      tick();
      in_valid = 1'b0;
      chk("lat_after_valid", out_valid, 1);
      chk("lat_after_alu", out_alu_data, 32'hDEADBEEF);
      chk("lat_count", count, 1);
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      chk("lat_drained", count, 0);

      // Fill and drain
      for (int i = 0; i < 4; i++) begin
         e = mk(10 + i, 32'h100 + 4*i);
         drive(e);
         q.push_back(e);
         tick();
      end
      in_valid = 1'b0;
      chk("fill_count", count, 4);
      chk("fill_in_ready", in_ready, 0);
      chk("fill_head_pc", out_pc, 32'h100);
      tick();
      chk("hold_stable_pc", out_pc, 32'h100);
      out_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         tick();
         chk("drain_count", count, 3 - i);
      end
      out_ready = 1'b0;
      chk("drain_out_valid", out_valid, 0);

      // Wrap: push/pop pairs at count=1
      e = mk(20, 32'h200);
      drive(e);
      q.push_back(e);
      tick();
      out_ready = 1'b1;
      for (int i = 0; i < 10; i++) begin
         e = mk(21 + i, 32'h204 + 4*i);
         drive(e);
         q.push_back(e);
         tick();
         chk("wrap_count", count, 1);
      end
      in_valid = 1'b0;
      tick();
      out_ready = 1'b0;
      chk("wrap_empty", count, 0);

      // Overflow: extra push while full is lost
      for (int i = 0; i < 4; i++) begin
         e = mk(40 + i, 32'h400 + 4*i);
         drive(e);
         q.push_back(e);
         tick();
      end
      chk("ovf_pre", overflow_err, 0);
      drive(mk(99, 32'hBAD));
      tick();
      in_valid = 1'b0;
      chk("ovf_set", overflow_err, 1);
      chk("ovf_count", count, 4);
      out_ready = 1'b1;
      for (int i = 0; i < 4; i++) tick();
      out_ready = 1'b0;
      chk("ovf_extra_lost", count, 0);
      flush = 1'b1;
      tick();
      flush = 1'b0;
      chk("ovf_after_flush", overflow_err, 1);
      chk("ovf_flush_drop", drop_cnt, 0);

      // Flush together with a push
      for (int i = 0; i < 3; i++) begin
         e = mk(50 + i, 32'h500 + 4*i);
         drive(e);
         q.push_back(e);
         tick();
      end
      in_valid = 1'b0;
      chk("fl_count3", count, 3);
      drive(mk(59, 32'h5FF));
      flush = 1'b1;
      tick();
      flush = 1'b0;
      in_valid = 1'b0;
      q.delete();
      chk("fl_count", count, 0);
      chk("fl_out_valid", out_valid, 0);
      chk("fl_drop", drop_cnt, 3);
      chk("fl_out_pc", out_pc, 0);
      tick();
      chk("fl_push_ignored", out_valid, 0);

      // Reset mid-stream with active handshakes
      for (int i = 0; i < 2; i++) begin
         e = mk(60 + i, 32'h600 + 4*i);
         drive(e);
         q.push_back(e);
         tick();
      end
      chk("mr_count2", count, 2);
      drive(mk(69, 32'h6FF));
      out_ready = 1'b1;
      rst = 1'b1;
      tick();
      rst = 1'b0;
      in_valid = 1'b0;
      out_ready = 1'b0;
      q.delete();
      chk("mr_count", count, 0);
      chk("mr_drop", drop_cnt, 0);
      chk("mr_ovf", overflow_err, 0);
      chk("mr_in_ready", in_ready, 1);
      chk("mr_out_valid", out_valid, 0);
      chk("mr_out_pc", out_pc, 0);
      chk("mr_out_alu", out_alu_data, 0);
      chk("mr_out_mem", out_memory_data, 0);
      chk("mr_out_ctrl", out_ctrl, 0);
      chk("mr_out_flg", {out_overflow_flag, out_zero_flag, out_compflg}, 0);

      // drop_cnt saturation: 4+4+4+4 clips at 15
      for (int r = 0; r < 4; r++) begin
         for (int i = 0; i < 4; i++) begin
            drive(mk(70 + i, 32'h700 + 4*i));
            tick();
         end
         in_valid = 1'b0;
         flush = 1'b1;
         tick();
         flush = 1'b0;
         chk("sat_drop", drop_cnt, (r == 3) ? 15 : 4*(r+1));
      end

      chk("sb_empty", q.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule

// File: doc/ex_result_fifo.md
EX_RESULT_FIFO -- requirements
Module: ex_result_fifo

Interface
Parameters (name, default, meaning):
REQ-001 The block SHALL have parameter DATA_W, 32, width of alu_data, memory_data and program_counter fields.
REQ-002 The block SHALL have parameter CTRL_W, 16, width of the packed control word.
REQ-003 The block SHALL have parameter DEPTH, 4, number of entries; power of two, >= 2.
REQ-004 The block SHALL have parameter CNT_W, 16, width of the flush-drop counter.

Ports (name, direction, width, meaning):
REQ-005 The block SHALL have port clk, in, 1, the single clock; reset is synchronous and active-high.
REQ-006 The block SHALL have port rst, in, 1, synchronous active-high reset.
REQ-007 The block SHALL have port in_valid, in, 1, EX stage presents a result.
REQ-008 The block SHALL have port in_ready, out, 1, the FIFO accepts a result.
REQ-009 The block SHALL have port in_ctrl, in, CTRL_W, packed control_out.
REQ-010 The block SHALL have ports in_alu_data, in_memory_data and in_pc, in, DATA_W each.
REQ-011 The block SHALL have ports in_overflow_flag, in_zero_flag and in_compflg, in, 1 each.
REQ-012 The block SHALL have port flush, in, 1, discard all stored entries.
REQ-013 The block SHALL have port out_valid, out, 1, the head entry is valid.
REQ-014 The block SHALL have port out_ready, in, 1, the consumer takes the head entry.
REQ-015 The block SHALL have ports out_ctrl, out_alu_data, out_memory_data, out_pc, out_overflow_flag, out_zero_flag and out_compflg, widths mirroring the inputs, carrying the head entry.
REQ-016 The block SHALL have port count, out, $clog2(DEPTH)+1, current occupancy.
REQ-017 The block SHALL have port overflow_err, out, 1, sticky push-while-full error.
REQ-018 The block SHALL have port drop_cnt, out, CNT_W, entries discarded by flush.

Function
REQ-019 Push SHALL occur on a rising clk edge when in_valid=1 and in_ready=1; the entry is written at the write pointer.
REQ-020 Pop SHALL occur on a rising clk edge when out_valid=1 and out_ready=1; the read pointer advances.
REQ-021 in_ready SHALL equal (count != DEPTH); push and pop at full SHALL NOT occur together, because in_ready=0.
REQ-022 out_valid SHALL equal (count != 0); outputs SHALL be first-word-fall-through from registered storage.
REQ-023 Latency SHALL be exactly 1 cycle: data pushed at edge N SHALL appear on the out_* ports with out_valid=1 after edge N; there is no combinational in-to-out path.
REQ-024 When out_valid=0, all out_* data ports SHALL be 0.
REQ-025 Simultaneous push and pop with 0 < count < DEPTH SHALL leave count unchanged and advance both pointers.
REQ-026 Pointers SHALL wrap from DEPTH-1 to 0; order SHALL be strictly FIFO across the wrap.
REQ-027 Flush SHALL have priority: on an edge with flush=1, the pointers and count SHALL go to 0, and any push or pop on that edge SHALL be ignored.
REQ-028 On a flush edge, drop_cnt SHALL increase by the pre-flush count, saturating at 2^CNT_W-1.
REQ-029 overflow_err SHALL set on any edge with in_valid=1, in_ready=0 and flush=0, and SHALL stay set until reset; flush does not clear it.
REQ-030 Stored entries SHALL NOT change while held; out_* SHALL be stable while out_valid=1 and out_ready=0.

Reset
REQ-031 On an edge with rst=1, count, both pointers, overflow_err and drop_cnt SHALL become 0, out_valid SHALL be 0 and in_ready SHALL be 1; rst overrides flush, push and pop.
REQ-032 Storage contents need not be cleared on reset, but out_* SHALL read 0 per REQ-024.
REQ-033 Reset asserted mid-operation, with a full FIFO and active handshakes, SHALL discard all entries and SHALL NOT count them in drop_cnt.

Verification
REQ-034 The bench SHALL cover fill and drain: push 4 entries with pc=0x100,0x104,0x108,0x10C and out_ready=0, giving count=4 and in_ready=0; then out_ready=1 pops them in order, one per cycle, ending at count=0.
REQ-035 The bench SHALL cover latency: push alu_data=0xDEADBEEF into the empty FIFO at edge N, so out_valid=1 and out_alu_data=0xDEADBEEF are seen after edge N, not before.
REQ-036 The bench SHALL cover wrap: 10 consecutive push/pop pairs at count=1 keep count=1 and pass all data through in order across pointer wrap.
REQ-037 The bench SHALL cover overflow: in_valid=1 while full gives overflow_err=1, the extra entry is lost and count stays 4; after a later flush, overflow_err is still 1.
REQ-038 The bench SHALL cover flush with a push: count=3, flush=1 together with in_valid=1 gives count=0, out_valid=0, drop_cnt=3 next cycle, and the pushed entry does not appear.
REQ-039 The bench SHALL cover reset mid-stream: count=2, rst=1 for one edge gives count=0, drop_cnt=0, overflow_err=0, in_ready=1 and out_* all 0.
